// File: rtl/shift_reg_seq.sv
// Parametrised load/shift register with serial/logical/arithmetic/rotate fill,
// single-step shifts and a sequenced shift-by-N with Busy/Done handshake.
module shift_reg_seq #(
  parameter int WIDTH = 33,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  input  logic [1:0]       Mode,
  input  logic             Dir,
  input  logic             Step,
  input  logic             Start,
  input  logic [CNT_W-1:0] Count,
  input  logic             ShiftR_In,
  input  logic             ShiftL_In,
  output logic             Busy,
  output logic             Done,
  output logic             ShiftR_Out,
  output logic             ShiftL_Out,
  output logic [WIDTH-1:0] Data_Out
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [1:0] M_SER = 2'b00;
  localparam logic [1:0] M_LOG = 2'b01;
  localparam logic [1:0] M_ARI = 2'b10;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [1:0]       mode_q, mode_d;
  logic             dir_q, dir_d;

  logic [1:0]       sh_mode;
  logic             sh_dir;
  logic             fill;
  logic [WIDTH-1:0] shifted;

  // The sequenced path uses the mode/dir captured at Start; single steps use live inputs.
  always_comb begin
    sh_mode = (state_q == SHIFT) ? mode_q : Mode;
    sh_dir  = (state_q == SHIFT) ? dir_q  : Dir;
    fill    = 1'b0;
    if (sh_dir) begin
      case (sh_mode)
        M_SER:   fill = ShiftL_In;
        M_LOG,
        M_ARI:   fill = 1'b0;
        default: fill = data_q[WIDTH-1];
      endcase
      shifted = {data_q[WIDTH-2:0], fill};
    end else begin
      case (sh_mode)
        M_SER:   fill = ShiftR_In;
        M_LOG:   fill = 1'b0;
        M_ARI:   fill = data_q[WIDTH-1];
        default: fill = data_q[0];
      endcase
      shifted = {fill, data_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    if (Load) begin
      data_d  = D;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            mode_d  = Mode;
            dir_d   = Dir;
            rem_d   = Count;
            state_d = (Count != '0) ? SHIFT : DONE;
          end else if (Step) begin
            data_d = shifted;
          end
        end
        SHIFT: begin
          data_d = shifted;
          rem_d  = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      mode_q  <= 2'b00;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
    end
  end

  assign Busy       = (state_q != IDLE);
  assign Done       = (state_q == DONE);
  assign Data_Out   = data_q;
  assign ShiftR_Out = data_q[0];
  assign ShiftL_Out = data_q[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_seq.sv
// Directed bench: a 33-bit instance for reset/load, an 8-bit instance for
// stepping, sequencing, boundaries, interference and abort.
module tb_shift_reg_seq;
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // 33-bit instance
  logic        rst33 = 1'b1, ld33 = 1'b0;
  logic [32:0] d33 = '0;
  logic        busy33, done33, sro33, slo33;
  logic [32:0] q33;

  shift_reg_seq u33 (
    .Clk(Clk), .Reset(rst33), .Load(ld33), .D(d33), .Mode(2'b00), .Dir(1'b0),
    .Step(1'b0), .Start(1'b0), .Count(6'd0), .ShiftR_In(1'b0), .ShiftL_In(1'b0),
    .Busy(busy33), .Done(done33), .ShiftR_Out(sro33), .ShiftL_Out(slo33), .Data_Out(q33)
  );

  // 8-bit instance
  logic       rst = 1'b1, ld = 1'b0, dir = 1'b0, step = 1'b0, start = 1'b0;
  logic       rin = 1'b0, lin = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] d = '0;
  logic [3:0] cnt = '0;
  logic       busy, done, sro, slo;
  logic [7:0] q;

  shift_reg_seq #(.WIDTH(8)) u8 (
    .Clk(Clk), .Reset(rst), .Load(ld), .D(d), .Mode(mode), .Dir(dir),
    .Step(step), .Start(start), .Count(cnt), .ShiftR_In(rin), .ShiftL_In(lin),
    .Busy(busy), .Done(done), .ShiftR_Out(sro), .ShiftL_Out(slo), .Data_Out(q)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load8(input logic [7:0] v);
    ld = 1'b1; d = v;
    tick();
    ld = 1'b0;
  endtask

  task automatic step8(input logic [1:0] m, input logic dr);
    mode = m; dir = dr; step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  // Starts a sequenced shift and observes up to 20 cycles after the Start edge.
  // Live Mode/Dir are scrambled after Start to confirm they were latched.
  task automatic run_seq(input logic [1:0] m, input logic dr, input logic [3:0] c,
                         input bit interfere, output int bcyc, output int dcnt,
                         output int dcyc, output logic [7:0] dval);
    bcyc = 0; dcnt = 0; dcyc = 0; dval = 'x;
    mode = m; dir = dr; cnt = c; start = 1'b1;
    tick();
    start = 1'b0; mode = ~m; dir = ~dr; rin = 1'b1; lin = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      if (busy) bcyc++;
      if (done) begin dcnt++; dcyc = i; dval = q; end
      if (interfere && i == 2) begin step = 1'b1; start = 1'b1; cnt = 4'd1; end
      tick();
      step = 1'b0; start = 1'b0;
    end
    rin = 1'b0; lin = 1'b0;
    chk("seq_idle_after", {63'd0, busy}, 64'd0);
  endtask

  int bc, dn, dc;
  logic [7:0] dv;

  initial begin
    // Reset state
    tick(); tick();
    chk("rst33_q", q33, 64'd0);
    chk("rst33_busy_done", {busy33, done33}, 64'd0);
    chk("rst8_q", q, 64'd0);
    chk("rst8_flags", {busy, done, sro, slo}, 64'd0);
    rst33 = 1'b0; rst = 1'b0;

    ld33 = 1'b1; d33 = 33'h1_2345_6789;
    tick();
    ld33 = 1'b0;
    chk("load33", q33, 64'h1_2345_6789);
    chk("load33_msb_lsb", {slo33, sro33}, 64'b11);

    // Single steps on 1001_0110
    load8(8'b1001_0110);
    chk("pre_step_sro_slo", {sro, slo}, 64'b01);
    rin = 1'b1;
    step8(2'b00, 1'b0);
    rin = 1'b0;
    chk("step_serial_r", q, 64'hCB);
    chk("step_no_busy_done", {busy, done}, 64'd0);
    load8(8'b1001_0110);
    step8(2'b10, 1'b0);
    chk("step_arith_r", q, 64'hCB);
    load8(8'b1001_0110);
    step8(2'b11, 1'b1);
    chk("step_rot_l", q, 64'h2D);
    load8(8'b1001_0110);
    step8(2'b10, 1'b1);
    chk("step_arith_l", q, 64'h2C);
    load8(8'b1001_0110);
    lin = 1'b1;
    step8(2'b00, 1'b1);
    lin = 1'b0;
    chk("step_serial_l", q, 64'h2D);

    // Sequenced rotate right by 3 on 0x81
    load8(8'h81);
    run_seq(2'b11, 1'b0, 4'd3, 1'b0, bc, dn, dc, dv);
    chk("seq3_busy_cycles", bc, 4);
    chk("seq3_done_count", dn, 1);
    chk("seq3_done_cycle", dc, 4);
    chk("seq3_data", dv, 64'h30);

    // Count = 0
    load8(8'h5A);
    run_seq(2'b01, 1'b0, 4'd0, 1'b0, bc, dn, dc, dv);
    chk("cnt0_busy_cycles", bc, 1);
    chk("cnt0_done_cycle", dc, 1);
    chk("cnt0_data", dv, 64'h5A);

    load8(8'hFF);
    run_seq(2'b01, 1'b1, 4'd9, 1'b0, bc, dn, dc, dv);
    chk("log_l9_data", dv, 64'h00);
    chk("log_l9_done_cycle", dc, 10);

    load8(8'h01);
    run_seq(2'b11, 1'b0, 4'd9, 1'b0, bc, dn, dc, dv);
    chk("rot_r9_data", dv, 64'h80);

    load8(8'h80);
    run_seq(2'b10, 1'b0, 4'd15, 1'b0, bc, dn, dc, dv);
    chk("ari_r15_data", dv, 64'hFF);
    chk("ari_r15_busy_cycles", bc, 16);

    // Step and Start during SHIFT are ignored
    load8(8'h01);
    run_seq(2'b01, 1'b1, 4'd5, 1'b1, bc, dn, dc, dv);
    chk("intf_data", dv, 64'h20);
    chk("intf_done_count", dn, 1);
    chk("intf_done_cycle", dc, 6);

    // Abort by Load
    load8(8'h0F);
    mode = 2'b01; dir = 1'b1; cnt = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("abort_mid_busy", {63'd0, busy}, 64'd1);
    load8(8'hA5);
    chk("abort_load_data", q, 64'hA5);
    chk("abort_load_busy", {busy, done}, 64'd0);
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) dn++;
      tick();
    end
    chk("abort_load_no_done", dn, 0);
    chk("abort_load_hold", q, 64'hA5);

    // Abort by Reset
    mode = 2'b01; dir = 1'b1; cnt = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_rst_data", q, 64'd0);
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) dn++;
      tick();
    end
    chk("abort_rst_no_done", dn, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/shift_reg_seq.md
# shift_reg_seq

Parametrised successor to the multiplier's fixed 33-bit load/shift register. It adds configurable width, four fill modes (serial, logical, arithmetic, rotate) and a sequenced multi-cycle "shift by N" operation with Busy/Done handshake. The single-step shift path still serves the shift-add multiplier datapath, and the sequenced path serves the divider and barrel-free normalisation.

## Interface
- WIDTH, 33: register width in bits, ≥2
- CNT_W, $clog2(WIDTH+1): width of shift-count input
- Clk  in  1  clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high; clock Clk
- Load  in  1  parallel load of D
- D  in  WIDTH  parallel load data
- Mode  in  2  fill mode: 00 serial, 01 logical, 10 arithmetic, 11 rotate
- Dir  in  1  0 = right (toward bit 0), 1 = left
- Step  in  1  single one-bit shift (idle only)
- Start  in  1  begin sequenced shift of Count bits (idle only)
- Count  in  CNT_W  shift amount, sampled with Start
- ShiftR_In  in  1  fill bit entering MSB on serial right shift
- ShiftL_In  in  1  fill bit entering LSB on serial left shift
- Busy  out  1  high while a sequenced shift is in progress or completing
- Done  out  1  one-cycle completion pulse
- ShiftR_Out  out  1  Data_Out[0], combinational
- ShiftL_Out  out  1  Data_Out[WIDTH-1], combinational
- Data_Out  out  WIDTH  register contents

## Operation
- FSM states: IDLE, SHIFT, DONE. Busy = (state != IDLE). Done = (state == DONE).
- One-bit shift, right: serial fills {ShiftR_In, q[W-1:1]}. Logical fills 0. Arithmetic fills q[W-1]. Rotate fills q[0].
- One-bit shift, left: serial fills {q[W-2:0], ShiftL_In}. Logical and arithmetic fill 0. Rotate fills q[W-1].
- Priority per edge: Reset > Load > Start > Step.
- IDLE + Load: q <= D.
- IDLE + Start: latch Mode, Dir and rem <= Count. Go to SHIFT if Count≠0, else go to DONE. No shift on this edge.
- IDLE + Step: one shift using live Mode/Dir. State stays IDLE. Done is not asserted.
- SHIFT: each edge does one shift with the latched Mode/Dir and rem <= rem-1. When rem==1, go to DONE.
- Serial fill bits are sampled live on every shift edge.
- DONE: lasts one cycle, then returns to IDLE.
- Load in SHIFT or DONE aborts the operation: q <= D, state <= IDLE, Done is not pulsed.
- Start and Step are ignored outside IDLE.
- Count > WIDTH is legal. Logical and serial modes flush fully. Arithmetic right saturates to all-sign. Rotate wraps modulo WIDTH.
- Reset: q = 0, state = IDLE, rem = 0. Resulting outputs: Data_Out=0, Busy=0, Done=0, ShiftR_Out=0, ShiftL_Out=0. Reset mid-operation discards the operation with no Done.

## Timing
- Load and Step take effect at the next edge. Data_Out is registered.
- Start with Count=N≥1 sampled at edge E0:
  - Shifts occur at E1..EN.
  - Busy is high from after E0 until E(N+1).
  - Done is high for the cycle between EN and E(N+1).
  - Data_Out holds the final value when Done is high.
  - Total latency from Start to Done is N+1 cycles.
- Start with Count=0 at E0: Done is high in the cycle after E0, Busy is high for that one cycle, and Data_Out is unchanged.
- A new Start is accepted at E(N+1), on the edge where DONE returns to IDLE, only if state is IDLE on that edge. The earliest back-to-back Start is therefore at the edge after Done falls.
- ShiftR_Out and ShiftL_Out follow Data_Out combinationally with no extra latency.

## Test plan
- Reset/load: assert Reset → Data_Out=0 and Busy=Done=0. Load D=33'h1_2345_6789 → Data_Out=33'h1_2345_6789 after one edge.
- Single step, WIDTH=8, q=8'b1001_0110:
  - Serial right with ShiftR_In=1 → 8'b1100_1011, ShiftR_Out was 0.
  - Arithmetic right → 8'b1100_1011.
  - Rotate left → 8'b0010_1101.
- Sequenced, WIDTH=8, q=8'h81, Start with Count=3, Mode=rotate, Dir=right:
  - Busy high for 4 cycles.
  - Done pulses exactly once, in cycle 4.
  - Data_Out=8'h30 when Done is high.
- Boundaries, WIDTH=8:
  - Count=0 → Done one cycle after Start, data unchanged.
  - Count=9 logical left on 8'hFF → 8'h00.
  - Count=9 rotate right on 8'h01 → 8'h80.
  - Arithmetic right Count=15 on 8'h80 → 8'hFF.
- Interference: Start Count=5, then pulse Step and a second Start during SHIFT → both ignored, final result reflects exactly 5 shifts.
- Abort: during SHIFT, Load D=8'hA5 → Data_Out=8'hA5, Busy drops the next cycle, no Done. Separately, Reset mid-SHIFT → Data_Out=0 and no Done.
